// File: rtl/logic_op_sequencer_pkg.sv
// Shared types and defaults for the logic_op_sequencer block.
package logic_op_sequencer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 4;

  localparam logic OP_OR  = 1'b0;
  localparam logic OP_AND = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/logic_op_sequencer_alu.sv
// Combinational bitwise OR/AND selected by op.
module logic_op_sequencer_alu
  import logic_op_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = (op == OP_AND) ? (a & b) : (a | b);

endmodule

// File: rtl/logic_op_sequencer.sv
// Command-driven OR/AND sequencer over a small register file with a result port.
// Optional zero flag output enabled by defining LOGIC_OP_SEQUENCER_ZERO_FLAG_EN.
module logic_op_sequencer
  import logic_op_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_OP,
  input  logic [AW-1:0]    CMD_RA,
  input  logic [AW-1:0]    CMD_RB,
  input  logic [AW-1:0]    CMD_RD,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic [AW-1:0]    RES_RD
`ifdef LOGIC_OP_SEQUENCER_ZERO_FLAG_EN
  ,
  output logic             RES_ZERO
`endif
);

  state_t state, state_nxt;

  logic                        op_q;
  logic [AW-1:0]               ra_q, rb_q, rd_q;
  logic [WIDTH-1:0]            opa_q, opb_q, alu_y;
  logic [NREGS-1:0][WIDTH-1:0] rf;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (CMD_VALID) state_nxt = READ;
      READ: state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (RES_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state == IDLE);
  end

  logic_op_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (opa_q),
    .b  (opb_q),
    .y  (alu_y)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q      <= OP_OR;
      ra_q      <= '0;
      rb_q      <= '0;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      RES_RD    <= '0;
`ifdef LOGIC_OP_SEQUENCER_ZERO_FLAG_EN
      RES_ZERO  <= 1'b0;
`endif
    end else begin
      if (CMD_VALID && CMD_READY) begin
        op_q <= CMD_OP;
        ra_q <= CMD_RA;
        rb_q <= CMD_RB;
        rd_q <= CMD_RD;
      end
      if (state == READ) begin
        opa_q <= rf[ra_q];
        opb_q <= rf[rb_q];
      end
      if (state == EXEC) begin
        RES_DATA  <= alu_y;
        RES_RD    <= rd_q;
        RES_VALID <= 1'b1;
`ifdef LOGIC_OP_SEQUENCER_ZERO_FLAG_EN
        RES_ZERO  <= (alu_y == '0);
`endif
      end
      if (state == RESP && RES_READY) RES_VALID <= 1'b0;
    end
  end

  // Writeback is ordered after the host write so it wins on an address collision.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rf <= '0;
    end else begin
      if (WR_EN)           rf[WR_ADDR] <= WR_DATA;
      if (state == EXEC)   rf[rd_q]    <= alu_y;
    end
  end

endmodule
